simd_alu_pipe: RTL

- Parametrised, pipelined successor to the current integer SIMD add/saturate/min/max/shift/logic unit.
- Operates on W-bit vectors split into 8/16/32/64-bit lanes and carries an opaque tag per operation.
- Uses a valid/ready handshake with full backpressure, so it can sit between the int-SIMD issue port and the result bus without a fixed-latency assumption.
- Corrects signed saturation, which now clamps to the lane MAX/MIN. Shifts become true variable shifts with full per-lane counts.

---
 rtl/simd_pkg.sv | 44 ++++
 rtl/simd_lane_alu.sv | 61 ++++++
 rtl/simd_alu_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared opcode encoding, lane-size codes and signed-limit helpers for the SIMD ALU.
package simd_pkg;

  typedef enum logic [4:0] {
    PADD    = 5'd0,
    PSUB    = 5'd1,
    PADDUS  = 5'd2,
    PSUBUS  = 5'd3,
    PADDS   = 5'd4,
    PSUBS   = 5'd5,
    PMINU   = 5'd6,
    PMAXU   = 5'd7,
    PMINS   = 5'd8,
    PMAXS   = 5'd9,
    PCMPEQ  = 5'd10,
    PCMPGTS = 5'd11,
    PCMPGTU = 5'd12,
    PSHL    = 5'd13,
    PSHR    = 5'd14,
    PSAR    = 5'd15,
    PAND    = 5'd16,
    POR     = 5'd17,
    PXOR    = 5'd18,
    PANDN   = 5'd19,
    PMOV    = 5'd20,
    PNOT    = 5'd21
  } simd_op_e;

  localparam logic [1:0] ESZ8  = 2'd0;
  localparam logic [1:0] ESZ16 = 2'd1;
  localparam logic [1:0] ESZ32 = 2'd2;
  localparam logic [1:0] ESZ64 = 2'd3;

  // Largest positive signed value of an e-bit lane, zero-extended to 64 bits.
  function automatic logic [63:0] lane_max_s(input int unsigned e);
    return (64'd1 << (e - 1)) - 64'd1;
  endfunction

  // Most negative signed value of an e-bit lane, as its e-bit pattern.
  function automatic logic [63:0] lane_min_s(input int unsigned e);
    return 64'd1 << (e - 1);
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One EW-bit lane of the arithmetic/compare/shift ops; logic ops are handled by the caller.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int unsigned EW = 8
) (
  input  logic [4:0]    op,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [EW-1:0] res
);

  localparam int unsigned SW      = $clog2(EW);
  localparam logic [63:0] MAX_S64 = lane_max_s(EW);
  localparam logic [63:0] MIN_S64 = lane_min_s(EW);
  localparam logic [63:0] EW64    = 64'(EW);
  localparam logic [EW-1:0] MAX_S = MAX_S64[EW-1:0];
  localparam logic [EW-1:0] MIN_S = MIN_S64[EW-1:0];
  localparam logic [EW-1:0] EW_V  = EW64[EW-1:0];

  logic [EW:0]   sum;
  logic [EW:0]   dif;
  logic          ovf_add;
  logic          ovf_sub;
  logic          big;
  logic [SW-1:0] sh;

  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  // Signed overflow: result sign disagrees with what the operand signs allow.
  assign ovf_add = (a[EW-1] == b[EW-1]) && (sum[EW-1] != a[EW-1]);
  assign ovf_sub = (a[EW-1] != b[EW-1]) && (dif[EW-1] != a[EW-1]);
  // Full-width count: anything >= EW shifts every bit out.
  assign big = (b >= EW_V);
  assign sh  = b[SW-1:0];

  // Per-op lane result; clamps pick MAX when A is non-negative, MIN otherwise.
  always_comb begin
    res = '0;
    case (op)
      PADD:    res = sum[EW-1:0];
      PSUB:    res = dif[EW-1:0];
      PADDUS:  res = sum[EW] ? {EW{1'b1}} : sum[EW-1:0];
      PSUBUS:  res = dif[EW] ? '0 : dif[EW-1:0];
      PADDS:   res = ovf_add ? (a[EW-1] ? MIN_S : MAX_S) : sum[EW-1:0];
      PSUBS:   res = ovf_sub ? (a[EW-1] ? MIN_S : MAX_S) : dif[EW-1:0];
      PMINU:   res = (b < a) ? b : a;
      PMAXU:   res = (b > a) ? b : a;
      PMINS:   res = ($signed(b) < $signed(a)) ? b : a;
      PMAXS:   res = ($signed(b) > $signed(a)) ? b : a;
      PCMPEQ:  res = (a == b) ? {EW{1'b1}} : '0;
      PCMPGTS: res = ($signed(a) > $signed(b)) ? {EW{1'b1}} : '0;
      PCMPGTU: res = (a > b) ? {EW{1'b1}} : '0;
      PSHL:    res = big ? '0 : (a << sh);
      PSHR:    res = big ? '0 : (a >> sh);
      PSAR:    res = big ? {EW{a[EW-1]}} : EW'($signed(a) >>> sh);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage valid/ready SIMD integer ALU: S1 operand register, S2 result register.
module simd_alu_pipe
  import simd_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [1:0]       in_esz,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic             s1_valid;
  logic [4:0]       s1_op;
  logic [1:0]       s1_esz;
  logic [TAG_W-1:0] s1_tag;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;

  logic             adv1;
  logic             adv2;
  logic [W-1:0]     res8;
  logic [W-1:0]     res16;
  logic [W-1:0]     res32;
  logic [W-1:0]     res64;
  logic [W-1:0]     alu_res;
  logic             alu_illegal;

  // S2 is the output register, so out_valid doubles as its valid bit.
  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;

  for (genvar i = 0; i < W / 8; i++) begin : g_l8
    simd_lane_alu #(.EW(8)) u_lane (
      .op (s1_op),
      .a  (s1_a[i*8 +: 8]),
      .b  (s1_b[i*8 +: 8]),
      .res(res8[i*8 +: 8])
    );
  end

  for (genvar i = 0; i < W / 16; i++) begin : g_l16
    simd_lane_alu #(.EW(16)) u_lane (
      .op (s1_op),
      .a  (s1_a[i*16 +: 16]),
      .b  (s1_b[i*16 +: 16]),
      .res(res16[i*16 +: 16])
    );
  end

  for (genvar i = 0; i < W / 32; i++) begin : g_l32
    simd_lane_alu #(.EW(32)) u_lane (
      .op (s1_op),
      .a  (s1_a[i*32 +: 32]),
      .b  (s1_b[i*32 +: 32]),
      .res(res32[i*32 +: 32])
    );
  end

  for (genvar i = 0; i < W / 64; i++) begin : g_l64
    simd_lane_alu #(.EW(64)) u_lane (
      .op (s1_op),
      .a  (s1_a[i*64 +: 64]),
      .b  (s1_b[i*64 +: 64]),
      .res(res64[i*64 +: 64])
    );
  end

  // Result mux: bitwise ops are lane-agnostic, the rest pick the lane bank by esz.
  always_comb begin
    alu_res     = '0;
    alu_illegal = (s1_op > PNOT);
    case (s1_op)
      PAND:    alu_res = s1_a & s1_b;
      POR:     alu_res = s1_a | s1_b;
      PXOR:    alu_res = s1_a ^ s1_b;
      PANDN:   alu_res = s1_a & ~s1_b;
      PMOV:    alu_res = s1_b;
      PNOT:    alu_res = ~s1_b;
      default: begin
        if (!alu_illegal) begin
          case (s1_esz)
            ESZ8:    alu_res = res8;
            ESZ16:   alu_res = res16;
            ESZ32:   alu_res = res32;
            default: alu_res = res64;
          endcase
        end
      end
    endcase
  end

  // S1 operand register: refills whenever it is empty or S2 can take its contents.
  always_ff @(negedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_esz   <= '0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_esz <= in_esz;
        s1_tag <= in_tag;
        s1_a   <= in_a;
        s1_b   <= in_b;
      end
    end
  end

  // S2 result register: holds every field while stalled by out_ready.
  always_ff @(negedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_res     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_res     <= alu_res;
        out_tag     <= s1_tag;
        out_illegal <= alu_illegal;
      end
    end
  end

endmodule
